press_arbiter: RTL and testbench

- Shares the single "step" resource of the game datapath (rope/light position) between two players' push-buttons.
- Converts each raw button level into one press event per release→press transition.
- Enforces a per-player cooldown and arbitrates same-cycle presses.
- Emits at most one registered one-cycle step pulse per player per cycle, never both in the same cycle.
- Sits between the synchronized key inputs and the playfield/score logic.

---
 rtl/game_pkg.sv | 10 +
 rtl/btn_edge_fsm.sv | 26 ++
 rtl/press_arbiter.sv | 99 +++++++++
 tb/tb_press_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the game datapath slice.
package game_pkg;

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} btn_state_t;

    typedef enum logic {P1 = 1'b0, P2 = 1'b1} player_t;

    localparam int unsigned DEFAULT_COOLDOWN = 4;

endpackage

// File: rtl/btn_edge_fsm.sv
// RELEASED/PRESSED one-shot: edge_out is high only while the state is RELEASED
// and the level is high, so a held button yields a single edge.
module btn_edge_fsm
    import game_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic edge_out
);

    btn_state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RELEASED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = RELEASED;
        edge_out  = 1'b0;
        if (level) state_nxt = PRESSED;
        edge_out = (state == RELEASED) & level;
    end

endmodule

// File: rtl/press_arbiter.sv
// Two-player press arbiter: edge detect, per-player cooldown, round-robin tie break.
// Optional macro PRESS_ARB_TIE_CANCEL_EN: a same-cycle collision grants no one.
module press_arbiter
    import game_pkg::*;
#(
    parameter int unsigned COOLDOWN = DEFAULT_COOLDOWN,
    parameter int unsigned CD_W     = 3
)
(
    input  logic clk,
    input  logic reset,
    input  logic p1_in,
    input  logic p2_in,
    input  logic game_active,
    output logic p1_step,
    output logic p2_step,
    output logic tie,
    output logic last_winner
);

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic            edge1, edge2;
    logic            req1, req2;
    logic            gnt1, gnt2, tie_nxt, cancel;
    logic            pend1, pend2, pend1_nxt, pend2_nxt;
    logic [CD_W-1:0] cd1, cd2;
    player_t         lw, lw_nxt;

    btn_edge_fsm u_edge1 (.clk(clk), .reset(reset), .level(p1_in), .edge_out(edge1));
    btn_edge_fsm u_edge2 (.clk(clk), .reset(reset), .level(p2_in), .edge_out(edge2));

    always_comb begin
        req1      = pend1 | (edge1 & (cd1 == '0) & ~pend1 & game_active);
        req2      = pend2 | (edge2 & (cd2 == '0) & ~pend2 & game_active);
        gnt1      = 1'b0;
        gnt2      = 1'b0;
        tie_nxt   = 1'b0;
        cancel    = 1'b0;
        pend1_nxt = pend1;
        pend2_nxt = pend2;
        lw_nxt    = lw;
        if (!game_active) begin
            pend1_nxt = 1'b0;
            pend2_nxt = 1'b0;
        end else if (req1 && req2) begin
            tie_nxt = 1'b1;
`ifdef PRESS_ARB_TIE_CANCEL_EN
            cancel = 1'b1;
`else
            // Winner is the player that did not win last; loser is queued.
            if (lw == P2) begin
                gnt1      = 1'b1;
                pend1_nxt = 1'b0;
                pend2_nxt = 1'b1;
                lw_nxt    = P1;
            end else begin
                gnt2      = 1'b1;
                pend2_nxt = 1'b0;
                pend1_nxt = 1'b1;
                lw_nxt    = P2;
            end
`endif
        end else if (req1) begin
            gnt1      = 1'b1;
            pend1_nxt = 1'b0;
            lw_nxt    = P1;
        end else if (req2) begin
            gnt2      = 1'b1;
            pend2_nxt = 1'b0;
            lw_nxt    = P2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_step <= 1'b0;
            p2_step <= 1'b0;
            tie     <= 1'b0;
            pend1   <= 1'b0;
            pend2   <= 1'b0;
            cd1     <= '0;
            cd2     <= '0;
            lw      <= P2;
        end else begin
            p1_step <= gnt1;
            p2_step <= gnt2;
            tie     <= tie_nxt;
            pend1   <= pend1_nxt;
            pend2   <= pend2_nxt;
            lw      <= lw_nxt;
            cd1     <= (gnt1 | cancel) ? CD_LOAD : ((cd1 != '0) ? cd1 - CD_W'(1) : cd1);
            cd2     <= (gnt2 | cancel) ? CD_LOAD : ((cd2 != '0) ? cd2 - CD_W'(1) : cd2);
        end
    end

    assign last_winner = lw;

endmodule

// File: tb/tb_press_arbiter.sv
// Scoreboard bench for press_arbiter: a cycle model pushes expected outputs, sampled 1ns after each edge.
module tb_press_arbiter;

    localparam int CD = 4;

    logic clk, reset, p1_in, p2_in, game_active;
    logic p1_step, p2_step, tie, last_winner;

    press_arbiter #(.COOLDOWN(CD), .CD_W(3)) dut (
        .clk(clk), .reset(reset), .p1_in(p1_in), .p2_in(p2_in),
        .game_active(game_active), .p1_step(p1_step), .p2_step(p2_step),
        .tie(tie), .last_winner(last_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic s1; logic s2; logic t; logic lw; } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int n1, n2, nt;

    // model state
    bit ms1, ms2, mpend1, mpend2, mlw;
    int mcd1, mcd2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        ms1 = 0; ms2 = 0; mpend1 = 0; mpend2 = 0; mcd1 = 0; mcd2 = 0; mlw = 1;
    endtask

    task automatic model_step(input bit a, input bit b, input bit ga);
        bit e1, e2, r1, r2, g1, g2, t, np1, np2, nlw, cancel;
        e1 = !ms1 && a;
        e2 = !ms2 && b;
        r1 = mpend1 || (e1 && mcd1 == 0 && ga);
        r2 = mpend2 || (e2 && mcd2 == 0 && ga);
        g1 = 0; g2 = 0; t = 0; cancel = 0;
        np1 = mpend1; np2 = mpend2; nlw = mlw;
        if (!ga) begin
            np1 = 0; np2 = 0;
        end else if (r1 && r2) begin
            t = 1;
`ifdef PRESS_ARB_TIE_CANCEL_EN
            cancel = 1;
`else
            if (mlw) begin g1 = 1; np1 = 0; np2 = 1; nlw = 0; end
            else     begin g2 = 1; np2 = 0; np1 = 1; nlw = 1; end
`endif
        end else if (r1) begin
            g1 = 1; np1 = 0; nlw = 0;
        end else if (r2) begin
            g2 = 1; np2 = 0; nlw = 1;
        end
        mcd1 = (g1 || cancel) ? CD : (mcd1 > 0 ? mcd1 - 1 : 0);
        mcd2 = (g2 || cancel) ? CD : (mcd2 > 0 ? mcd2 - 1 : 0);
        ms1 = a; ms2 = b; mpend1 = np1; mpend2 = np2; mlw = nlw;
        sb.push_back('{s1: g1, s2: g2, t: t, lw: nlw});
    endtask

    task automatic cycle(input bit a, input bit b, input bit ga);
        exp_t e;
        p1_in = a; p2_in = b; game_active = ga;
        model_step(a, b, ga);
        @(posedge clk); #1;
        e = sb.pop_front();
        check("p1_step", p1_step, e.s1);
        check("p2_step", p2_step, e.s2);
        check("tie", tie, e.t);
        check("last_winner", last_winner, e.lw);
        check("exclusive", p1_step & p2_step, 0);
        n1 += int'(p1_step); n2 += int'(p2_step); nt += int'(tie);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1);
    endtask

    task automatic clr();
        n1 = 0; n2 = 0; nt = 0;
    endtask

    initial begin
        reset = 0; p1_in = 0; p2_in = 0; game_active = 1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst_p1", p1_step, 0);
            check("rst_p2", p2_step, 0);
            check("rst_tie", tie, 0);
            check("rst_lw", last_winner, 1);
        end
        #3 reset = 1;

        // single held press
        clr();
        for (int i = 0; i < 6; i++) cycle(1, 0, 1);
        check("hold_n1", n1, 1);
        check("hold_nt", nt, 0);
        check("hold_lw", last_winner, 0);
        idle(5);

        // cooldown: presses at +0 granted, +2 and +4 dropped, +6 granted
        clr();
        for (int i = 0; i < 4; i++) begin cycle(0, 1, 1); cycle(0, 0, 1); end
        check("cd_n2", n2, 2);
        idle(5);
        // exact cooldown boundary: press 5 cycles after a grant succeeds
        clr();
        cycle(0, 1, 1); idle(4); cycle(0, 1, 1); cycle(0, 0, 1);
        check("cd_edge_n2", n2, 2);
        idle(5);

        // collision, last winner P2 -> P1 first, P2 next cycle
        clr();
        cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 1, 1); cycle(0, 0, 1);
`ifdef PRESS_ARB_TIE_CANCEL_EN
        check("col_n1", n1, 0); check("col_n2", n2, 0);
`else
        check("col_n1", n1, 1); check("col_n2", n2, 1);
`endif
        check("col_nt", nt, 1);
        idle(5);
        // after a P1 grant, the next collision goes to P2 first
        cycle(1, 0, 1); idle(5);
        clr();
        cycle(1, 1, 1);
`ifndef PRESS_ARB_TIE_CANCEL_EN
        check("col2_first_p2", {p1_step, p2_step}, 2'b01);
`endif
        cycle(0, 0, 1); cycle(0, 0, 1);
        check("col2_nt", nt, 1);
        idle(5);

        // freeze right after a collision: pending loser flushed, held buttons give nothing
        cycle(0, 1, 1); idle(5);
        clr();
        cycle(1, 1, 1);
        cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0);
        cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 1, 1);
`ifndef PRESS_ARB_TIE_CANCEL_EN
        check("frz_n1", n1, 1);
`endif
        check("frz_n2", n2, 0);
        check("frz_nt", nt, 1);
        idle(5);

        // async reset two cycles after a grant
        cycle(1, 0, 1); cycle(0, 0, 1); cycle(0, 0, 1);
        #3 reset = 0;
        #1;
        check("areset_p1", p1_step, 0);
        check("areset_tie", tie, 0);
        check("areset_lw", last_winner, 1);
        model_reset();
        @(posedge clk); #1;
        check("areset_hold_p1", p1_step, 0);
        #3 reset = 1;
        clr();
        cycle(1, 0, 1);
        check("post_reset_grant", p1_step, 1);
        cycle(0, 0, 1);
        idle(5);

        // random traffic against the model
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
